// File: rtl/otter_lsu.sv
// OTTER load/store unit: req/gnt/rvld bus handshake, byte-lane steering, load extension,
// misalignment rejection and WAIT timeout. Define OTTER_LSU_MISALIGN_SPLIT_EN for two-beat misaligned accesses.
module otter_lsu #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TMO_W          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_vld,
    output logic        req_rdy,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_vld,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_misalign,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_strb,
    input  logic        bus_gnt,
    input  logic        bus_rvld,
    input  logic [31:0] bus_rdata,
    input  logic        bus_err
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_RESP = 3'd3
`ifdef OTTER_LSU_MISALIGN_SPLIT_EN
        , S_REQ2  = 3'd4
        , S_WAIT2 = 3'd5
`endif
    } state_t;

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t            state_q, state_d;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              tmo;
    logic              we_q;
    logic [2:0]        funct3_q;
    logic [1:0]        off_q;
    logic [31:0]       rsp_rdata_q;
    logic              rsp_err_q;

    // request decode
    logic [1:0]  off;
    logic [3:0]  mask4;
    logic        illegal;
    logic        reject_mis;
    logic [3:0]  strb_lo;
    logic [31:0] wdata_lo;
    logic [31:0] ld_d;

    assign off     = req_addr[1:0];
    assign mask4   = (req_funct3[1:0] == 2'b00) ? 4'b0001 :
                     (req_funct3[1:0] == 2'b01) ? 4'b0011 : 4'b1111;
    assign illegal = req_we ? (req_funct3 >= 3'b011)
                            : ((req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11));

`ifdef OTTER_LSU_MISALIGN_SPLIT_EN
    logic [3:0]  strb_hi, strb_hi_q;
    logic [31:0] wdata_hi, wdata_hi_q, rd1_q;
    logic        cross_q;
    logic [31:0] ld_lo, ld_hi;

    assign reject_mis          = 1'b0;
    assign {strb_hi, strb_lo}   = {4'b0, mask4} << off;
    assign {wdata_hi, wdata_lo} = {32'b0, req_wdata} << {off, 3'b000};
    // beat 2 data lands above beat 1 so one shift covers both single- and two-beat loads
    assign ld_lo = (state_q == S_WAIT2) ? rd1_q : bus_rdata;
    assign ld_hi = (state_q == S_WAIT2) ? bus_rdata : 32'h0;
    assign ld_d  = 32'({ld_hi, ld_lo} >> {off_q, 3'b000});
    assign rsp_misalign = 1'b0;
`else
    logic rsp_mis_q;

    assign reject_mis = ((req_funct3[1:0] == 2'b01) && off[0]) ||
                        ((req_funct3[1:0] == 2'b10) && (off != 2'b00));
    assign strb_lo    = mask4 << off;
    assign wdata_lo   = req_wdata << {off, 3'b000};
    assign ld_d       = bus_rdata >> {off_q, 3'b000};
    assign rsp_misalign = rsp_mis_q;
`endif

    function automatic logic [31:0] ld_ext(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            3'b000:  ld_ext = {{24{d[7]}}, d[7:0]};
            3'b001:  ld_ext = {{16{d[15]}}, d[15:0]};
            3'b100:  ld_ext = {24'b0, d[7:0]};
            3'b101:  ld_ext = {16'b0, d[15:0]};
            default: ld_ext = d;
        endcase
    endfunction

    logic [31:0] final_rdata;
    assign final_rdata = (we_q || bus_err) ? 32'h0 : ld_ext(funct3_q, ld_d);
    assign tmo = (TIMEOUT_CYCLES != 0) && (tmo_cnt == TMO_LAST);

    // state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (req_vld) state_d = (illegal || reject_mis) ? S_RESP : S_REQ;
            S_REQ:  if (bus_gnt) state_d = S_WAIT;
            S_WAIT: begin
                if (bus_rvld) begin
`ifdef OTTER_LSU_MISALIGN_SPLIT_EN
                    state_d = (!bus_err && cross_q) ? S_REQ2 : S_RESP;
`else
                    state_d = S_RESP;
`endif
                end else if (tmo) begin
                    state_d = S_RESP;
                end
            end
`ifdef OTTER_LSU_MISALIGN_SPLIT_EN
            S_REQ2:  if (bus_gnt) state_d = S_WAIT2;
            S_WAIT2: if (bus_rvld || tmo) state_d = S_RESP;
`endif
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // outputs
    always_comb begin
        req_rdy = (state_q == S_IDLE) && !rst;
        rsp_vld = (state_q == S_RESP);
`ifdef OTTER_LSU_MISALIGN_SPLIT_EN
        bus_req = (state_q == S_REQ) || (state_q == S_REQ2);
`else
        bus_req = (state_q == S_REQ);
`endif
    end

    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    // counter only runs in the wait states, so it restarts for every beat
    always_ff @(posedge clk) begin
        if (rst)
            tmo_cnt <= '0;
`ifdef OTTER_LSU_MISALIGN_SPLIT_EN
        else if (state_q == S_WAIT || state_q == S_WAIT2)
`else
        else if (state_q == S_WAIT)
`endif
            tmo_cnt <= tmo_cnt + 1'b1;
        else
            tmo_cnt <= '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q        <= 1'b0;
            funct3_q    <= 3'b0;
            off_q       <= 2'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= 32'h0;
            bus_wdata   <= 32'h0;
            bus_strb    <= 4'h0;
`ifdef OTTER_LSU_MISALIGN_SPLIT_EN
            strb_hi_q   <= 4'h0;
            wdata_hi_q  <= 32'h0;
            rd1_q       <= 32'h0;
            cross_q     <= 1'b0;
`else
            rsp_mis_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: if (req_vld) begin
                    we_q        <= req_we;
                    funct3_q    <= req_funct3;
                    off_q       <= off;
                    rsp_rdata_q <= 32'h0;
                    rsp_err_q   <= illegal;
                    bus_we      <= req_we;
                    bus_addr    <= {req_addr[31:2], 2'b00};
                    bus_strb    <= req_we ? strb_lo : 4'h0;
                    bus_wdata   <= req_we ? wdata_lo : 32'h0;
`ifdef OTTER_LSU_MISALIGN_SPLIT_EN
                    strb_hi_q   <= req_we ? strb_hi : 4'h0;
                    wdata_hi_q  <= req_we ? wdata_hi : 32'h0;
                    cross_q     <= |strb_hi;
`else
                    rsp_mis_q   <= !illegal && reject_mis;
`endif
                end
                S_WAIT: begin
                    if (bus_rvld) begin
`ifdef OTTER_LSU_MISALIGN_SPLIT_EN
                        if (!bus_err && cross_q) begin
                            rd1_q     <= bus_rdata;
                            bus_addr  <= bus_addr + 32'd4;
                            bus_strb  <= strb_hi_q;
                            bus_wdata <= wdata_hi_q;
                        end else
`endif
                        begin
                            rsp_err_q   <= bus_err;
                            rsp_rdata_q <= final_rdata;
                        end
                    end else if (tmo) begin
                        rsp_err_q <= 1'b1;
                    end
                end
`ifdef OTTER_LSU_MISALIGN_SPLIT_EN
                S_WAIT2: begin
                    if (bus_rvld) begin
                        rsp_err_q   <= bus_err;
                        rsp_rdata_q <= final_rdata;
                    end else if (tmo) begin
                        rsp_err_q <= 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_otter_lsu.sv
// Directed bench for otter_lsu: a small bus responder plus hand-computed expectations.
module tb_otter_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_vld, req_rdy, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_vld, rsp_err, rsp_misalign;
    logic [31:0] rsp_rdata;
    logic        bus_req, bus_we, bus_gnt, bus_rvld, bus_err;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_strb;

    otter_lsu #(.TIMEOUT_CYCLES(4), .TMO_W(8)) dut (
        .clk(clk), .rst(rst),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_vld(rsp_vld), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_misalign(rsp_misalign),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_strb(bus_strb), .bus_gnt(bus_gnt), .bus_rvld(bus_rvld), .bus_rdata(bus_rdata),
        .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, act, exp);
    endtask

    // results of the last access
    logic        got, r_err, r_mis, cap_we;
    logic [31:0] r_rdata, cap_addr0, cap_addr1, cap_wdata;
    logic [3:0]  cap_strb;
    int          lat, n_gnt;

    // issue one access, grant every bus request immediately, answer each beat one cycle later
    task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr, wd,
                          input logic [31:0] d0, d1, input logic err, input bit respond);
        bit pend;
        int beat;
        got = 0; lat = 0; n_gnt = 0; pend = 0; beat = 0;
        cap_addr0 = 32'hx; cap_addr1 = 32'hx;
        req_vld = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(posedge clk); #1;
        req_vld = 1'b0;
        for (int c = 1; c <= 40 && !got; c++) begin
            bus_gnt = 1'b0; bus_rvld = 1'b0; bus_err = 1'b0; bus_rdata = 32'h0;
            if (pend) begin
                bus_rvld = 1'b1; bus_err = err; bus_rdata = (beat == 0) ? d0 : d1;
                pend = 0; beat++;
            end else if (bus_req) begin
                if (n_gnt == 0) begin
                    cap_we = bus_we; cap_addr0 = bus_addr; cap_strb = bus_strb; cap_wdata = bus_wdata;
                end else begin
                    cap_addr1 = bus_addr;
                end
                bus_gnt = 1'b1; n_gnt++; pend = respond;
            end
            if (rsp_vld) begin
                got = 1; lat = c; r_rdata = rsp_rdata; r_err = rsp_err; r_mis = rsp_misalign;
            end
            @(posedge clk); #1;
        end
        bus_gnt = 1'b0; bus_rvld = 1'b0; bus_err = 1'b0;
        chk("rsp_seen", 32'(got), 32'd1);
        chk("rsp_one_cycle", 32'(rsp_vld), 32'd0);
    endtask

    initial begin
        rst = 1'b1; req_vld = 1'b0; req_we = 1'b0; req_funct3 = 3'b0; req_addr = 32'h0; req_wdata = 32'h0;
        bus_gnt = 1'b0; bus_rvld = 1'b0; bus_rdata = 32'h0; bus_err = 1'b0;
        repeat (2) @(posedge clk); #1;
        chk("rst_rdy", 32'(req_rdy), 32'd0);
        chk("rst_bus_req", 32'(bus_req), 32'd0);
        chk("rst_rsp_vld", 32'(rsp_vld), 32'd0);
        chk("rst_bus_addr", bus_addr, 32'h0);
        chk("rst_bus_strb", 32'(bus_strb), 32'h0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_rdy", 32'(req_rdy), 32'd1);

        // LW minimum latency
        access(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 32'h0, 1'b0, 1);
        chk("lw_lat", 32'(lat), 32'd3);
        chk("lw_data", r_rdata, 32'hDEADBEEF);
        chk("lw_err", 32'(r_err), 32'd0);
        chk("lw_addr", cap_addr0, 32'h100);
        chk("lw_strb", 32'(cap_strb), 32'h0);
        chk("lw_we", 32'(cap_we), 32'd0);

        // load extension / steering
        access(1'b0, 3'b000, 32'h103, 32'h0, 32'h80AABBCC, 32'h0, 1'b0, 1);
        chk("lb_addr", cap_addr0, 32'h100);
        chk("lb_data", r_rdata, 32'hFFFFFF80);
        access(1'b0, 3'b100, 32'h103, 32'h0, 32'h80AABBCC, 32'h0, 1'b0, 1);
        chk("lbu_data", r_rdata, 32'h00000080);
        access(1'b0, 3'b101, 32'h102, 32'h0, 32'h80AABBCC, 32'h0, 1'b0, 1);
        chk("lhu_data", r_rdata, 32'h000080AA);
        access(1'b0, 3'b001, 32'h102, 32'h0, 32'h80AABBCC, 32'h0, 1'b0, 1);
        chk("lh_data", r_rdata, 32'hFFFF80AA);
        access(1'b0, 3'b000, 32'h101, 32'h0, 32'h80AABBCC, 32'h0, 1'b0, 1);
        chk("lb_pos_data", r_rdata, 32'hFFFFFFBB);

        // stores
        access(1'b1, 3'b001, 32'h102, 32'h1234, 32'h0, 32'h0, 1'b1, 1);
        chk("sh_strb", 32'(cap_strb), 32'hC);
        chk("sh_wdata", cap_wdata, 32'h12340000);
        chk("sh_we", 32'(cap_we), 32'd1);
        chk("sh_err", 32'(r_err), 32'd1);
        chk("sh_rdata", r_rdata, 32'h0);
        access(1'b1, 3'b000, 32'h101, 32'hAB, 32'h0, 32'h0, 1'b0, 1);
        chk("sb_strb", 32'(cap_strb), 32'h2);
        chk("sb_wdata", cap_wdata, 32'h0000AB00);
        chk("sb_err", 32'(r_err), 32'd0);
        access(1'b1, 3'b010, 32'h104, 32'hCAFEF00D, 32'h0, 32'h0, 1'b0, 1);
        chk("sw_strb", 32'(cap_strb), 32'hF);
        chk("sw_addr", cap_addr0, 32'h104);
        chk("sw_wdata", cap_wdata, 32'hCAFEF00D);

        // illegal funct3: no bus cycle
        access(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 32'h0, 1'b0, 1);
        chk("ill_ld_err", 32'(r_err), 32'd1);
        chk("ill_ld_gnt", 32'(n_gnt), 32'd0);
        chk("ill_ld_lat", 32'(lat), 32'd1);
        access(1'b1, 3'b100, 32'h100, 32'h0, 32'h0, 32'h0, 1'b0, 1);
        chk("ill_st_err", 32'(r_err), 32'd1);
        chk("ill_st_gnt", 32'(n_gnt), 32'd0);

        // timeout after 4 WAIT cycles, stray rvld ignored, next access clean
        access(1'b0, 3'b010, 32'h200, 32'h0, 32'h0, 32'h0, 1'b0, 0);
        chk("tmo_lat", 32'(lat), 32'd6);
        chk("tmo_err", 32'(r_err), 32'd1);
        chk("tmo_rdata", r_rdata, 32'h0);
        bus_rvld = 1'b1; bus_err = 1'b1; bus_rdata = 32'h5A5A5A5A;
        @(posedge clk); #1;
        bus_rvld = 1'b0; bus_err = 1'b0;
        chk("stray_rsp", 32'(rsp_vld), 32'd0);
        chk("stray_rdy", 32'(req_rdy), 32'd1);
        access(1'b0, 3'b010, 32'h200, 32'h0, 32'h13579BDF, 32'h0, 1'b0, 1);
        chk("after_tmo_data", r_rdata, 32'h13579BDF);
        chk("after_tmo_err", 32'(r_err), 32'd0);
        chk("after_tmo_lat", 32'(lat), 32'd3);

        // misaligned word
        access(1'b0, 3'b010, 32'h101, 32'h0, 32'h44332211, 32'h88776655, 1'b0, 1);
`ifdef OTTER_LSU_MISALIGN_SPLIT_EN
        chk("mis_beats", 32'(n_gnt), 32'd2);
        chk("mis_addr0", cap_addr0, 32'h100);
        chk("mis_addr1", cap_addr1, 32'h104);
        chk("mis_data", r_rdata, 32'h55443322);
        chk("mis_flag", 32'(r_mis), 32'd0);
`else
        chk("mis_gnt", 32'(n_gnt), 32'd0);
        chk("mis_flag", 32'(r_mis), 32'd1);
        chk("mis_err", 32'(r_err), 32'd0);
        chk("mis_lat", 32'(lat), 32'd1);
        access(1'b1, 3'b001, 32'h103, 32'h1234, 32'h0, 32'h0, 1'b0, 1);
        chk("mis_sh_flag", 32'(r_mis), 32'd1);
        chk("mis_sh_gnt", 32'(n_gnt), 32'd0);
`endif

        // reset while in WAIT
        req_vld = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h300;
        @(posedge clk); #1;
        req_vld = 1'b0;
        chk("r6_req", 32'(bus_req), 32'd1);
        bus_gnt = 1'b1;
        @(posedge clk); #1;
        bus_gnt = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("r6_rdy", 32'(req_rdy), 32'd0);
        chk("r6_bus_req", 32'(bus_req), 32'd0);
        chk("r6_rsp", 32'(rsp_vld), 32'd0);
        chk("r6_addr", bus_addr, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("r6_rdy_rel", 32'(req_rdy), 32'd1);
        chk("r6_rsp_rel", 32'(rsp_vld), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
